pwm_cfg_scheduler: RTL and testbench

Sequences decoded SPI write frames into the PWM configuration registers. Frames are buffered in a small FIFO and validated, then written into a shadow register bank. The shadow bank is committed to the live PWM-facing registers only at a PWM period boundary, so the PWM core never sees a partially updated configuration. The block sits between the SPI peripheral's frame output and the PWM generator.

---
 rtl/pwm_cfg_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_pwm_cfg_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_scheduler.sv
// rtl/pwm_cfg_scheduler.sv - SPI frame FIFO, shadow register bank and period-aligned commit for the PWM core
//
// Purpose:
//   Decoded SPI write frames are queued in a small FIFO and then validated
//   one at a time by an IDLE/FETCH/EXEC sequencer. Valid writes land in a
//   shadow bank. The whole bank is copied to the live PWM-facing registers
//   only on a PWM period end, so the PWM core never sees a partial update.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   frame_valid    in   one-cycle pulse, frame_data holds a complete frame
//   frame_data     in   [15] write flag, [14:8] address, [7:0] data
//   frame_ready    out  FIFO not full
//   pwm_period_end in   one-cycle pulse on the last cycle of a PWM period
//   en_out         out  live reg 1 (hi byte) / reg 0 (lo byte)
//   pwm_en         out  live reg 3 (hi byte) / reg 2 (lo byte)
//   duty           out  live reg 4
//   pending        out  shadow bank holds uncommitted writes
//   commit_pulse   out  high for the cycle after a commit
//   drop_count     out  saturating count of discarded frames

module pwm_cfg_scheduler #(
   parameter int MAX_ADDR   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_valid,
   input  logic [15:0] frame_data,
   output logic        frame_ready,
   input  logic        pwm_period_end,
   output logic [15:0] en_out,
   output logic [15:0] pwm_en,
   output logic [7:0]  duty,
   output logic        pending,
   output logic        commit_pulse,
   output logic [7:0]  drop_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [6:0] MAX_ADDR_C = 7'(MAX_ADDR);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC
   } state_t;

   // ---------------- frame FIFO ----------------
   logic [15:0] fifo_q [FIFO_DEPTH];
   logic [PW:0] wr_ptr_q;
   logic [PW:0] rd_ptr_q;
   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;
   logic        overflow;

   // The extra wrap bit separates full (same index, different lap) from empty.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign push       = frame_valid && !fifo_full;
   assign overflow   = frame_valid && fifo_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= frame_data;
            wr_ptr_q                 <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // ---------------- sequencer ----------------
   state_t      state_q;
   state_t      state_d;
   logic [15:0] decode_q;
   logic [6:0]  dec_addr;
   logic        dec_ok;
   logic        exec_write;
   logic        exec_drop;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE:  if (!fifo_empty) state_d = S_FETCH;
         S_FETCH: begin
            pop     = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         decode_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_FETCH) begin
            decode_q <= fifo_q[rd_ptr_q[PW-1:0]];
         end
      end
   end

   assign dec_addr   = decode_q[14:8];
   assign dec_ok     = decode_q[15] && (dec_addr <= MAX_ADDR_C);
   assign exec_write = (state_q == S_EXEC) && dec_ok;
   assign exec_drop  = (state_q == S_EXEC) && !dec_ok;

   // ---------------- shadow / live banks ----------------
   logic [7:0] shadow_q [MAX_ADDR+1];
   logic [7:0] shadow_d [MAX_ADDR+1];
   logic [7:0] live_q   [MAX_ADDR+1];
   logic       dirty_q;
   logic       dirty_d;
   logic       commit;
   logic       commit_pulse_q;

   always_comb begin
      for (int i = 0; i <= MAX_ADDR; i++) begin
         shadow_d[i] = shadow_q[i];
         if (exec_write && (dec_addr == 7'(i))) begin
            shadow_d[i] = decode_q[7:0];
         end
      end
   end

   assign commit = pwm_period_end && dirty_q;

   // A write landing on the commit edge re-arms dirty, so it goes out next period.
   always_comb begin
      dirty_d = dirty_q;
      if (commit) dirty_d = 1'b0;
      if (exec_write) dirty_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= MAX_ADDR; i++) begin
            shadow_q[i] <= '0;
            live_q[i]   <= '0;
         end
         dirty_q        <= 1'b0;
         commit_pulse_q <= 1'b0;
      end else begin
         for (int i = 0; i <= MAX_ADDR; i++) begin
            shadow_q[i] <= shadow_d[i];
            // Copy the pre-write shadow so a same-edge write is not split in.
            if (commit) live_q[i] <= shadow_q[i];
         end
         dirty_q        <= dirty_d;
         commit_pulse_q <= commit;
      end
   end

   // ---------------- drop counter ----------------
   logic [7:0] drop_q;
   logic [7:0] drop_d;
   logic [1:0] drop_inc;
   logic [8:0] drop_sum;

   always_comb begin
      drop_inc = {1'b0, overflow} + {1'b0, exec_drop};
      drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) drop_q <= '0;
      else     drop_q <= drop_d;
   end

   // ---------------- outputs ----------------
   assign frame_ready  = !fifo_full;
   assign en_out       = {live_q[1], live_q[0]};
   assign pwm_en       = {live_q[3], live_q[2]};
   assign duty         = live_q[4];
   assign pending      = dirty_q;
   assign commit_pulse = commit_pulse_q;
   assign drop_count   = drop_q;

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// tb/tb_pwm_cfg_scheduler.sv - scoreboard bench for pwm_cfg_scheduler

module tb_pwm_cfg_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_valid = 1'b0;
   logic [15:0] frame_data = '0;
   logic        pwm_period_end = 1'b0;
   logic        frame_ready;
   logic [15:0] en_out;
   logic [15:0] pwm_en;
   logic [7:0]  duty;
   logic        pending;
   logic        commit_pulse;
   logic [7:0]  drop_count;

   always #5 clk = ~clk;

   pwm_cfg_scheduler #(.MAX_ADDR(4), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .frame_valid    (frame_valid),
      .frame_data     (frame_data),
      .frame_ready    (frame_ready),
      .pwm_period_end (pwm_period_end),
      .en_out         (en_out),
      .pwm_en         (pwm_en),
      .duty           (duty),
      .pending        (pending),
      .commit_pulse   (commit_pulse),
      .drop_count     (drop_count)
   );

   typedef struct {
      int          push;
      int          pop;
      int          apply;
      logic [15:0] d;
   } fr_t;

   typedef struct {
      logic       pend;
      logic [7:0] drop;
      logic       rdy;
      logic       cp;
   } st_t;

   fr_t         m_fr[$];
   st_t         stq[$];
   logic [39:0] cq[$];
   logic [7:0]  m_sh[5];
   logic        m_dirty = 1'b0;
   int          m_drop = 0;
   int          ek = 0;
   int          last_apply = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [39:0] cur_live = '0;
   bit          mon_en = 1'b0;
   st_t         mon_e;

   function automatic logic [39:0] pack_live();
      return {m_sh[1], m_sh[0], m_sh[3], m_sh[2], m_sh[4]};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: pops one expected status per cycle, and one expected live image per commit pulse.
   always @(negedge clk) begin
      if (rst) begin
         stq.delete();
         cq.delete();
         cur_live = '0;
      end else if (mon_en && stq.size() > 0) begin
         mon_e = stq.pop_front();
         check("pending", pending, mon_e.pend);
         check("drop_count", drop_count, mon_e.drop);
         check("frame_ready", frame_ready, mon_e.rdy);
         check("commit_pulse", commit_pulse, mon_e.cp);
         if (commit_pulse) begin
            if (cq.size() == 0) check("commit_unexpected", 1, 0);
            else cur_live = cq.pop_front();
         end
         check("live_regs", {en_out, pwm_en, duty}, cur_live);
      end
   end

   // Reference model: each accepted frame is popped 2 edges and applied 3 edges
   // after the sequencer can first start on it; one frame in service at a time.
   task automatic step(input logic fv, input logic [15:0] fd, input logic pe);
      int          occ;
      int          rdy_cnt;
      int          n_drop;
      int          st;
      int          a;
      logic [39:0] snap;
      bit          cm;
      st_t         s;
      fr_t         f;
      frame_valid    = fv;
      frame_data     = fd;
      pwm_period_end = pe;
      ek++;
      occ = 0;
      foreach (m_fr[i]) if (m_fr[i].push < ek && m_fr[i].pop >= ek) occ++;
      cm   = pe && m_dirty;
      snap = pack_live();
      if (cm) m_dirty = 1'b0;
      n_drop = 0;
      foreach (m_fr[i]) begin
         if (m_fr[i].apply == ek) begin
            a = int'(m_fr[i].d[14:8]);
            if (m_fr[i].d[15] && a <= 4) begin
               m_sh[a] = m_fr[i].d[7:0];
               m_dirty = 1'b1;
            end else begin
               n_drop++;
            end
         end
      end
      if (fv) begin
         if (occ < 4) begin
            st         = (ek + 1 > last_apply + 1) ? ek + 1 : last_apply + 1;
            f.push     = ek;
            f.pop      = st + 1;
            f.apply    = st + 2;
            f.d        = fd;
            last_apply = f.apply;
            m_fr.push_back(f);
         end else begin
            n_drop++;
         end
      end
      m_drop = (m_drop + n_drop > 255) ? 255 : m_drop + n_drop;
      while (m_fr.size() > 0 && m_fr[0].apply <= ek) void'(m_fr.pop_front());
      rdy_cnt = 0;
      foreach (m_fr[i]) if (m_fr[i].push <= ek && m_fr[i].pop > ek) rdy_cnt++;
      s.pend = m_dirty;
      s.drop = 8'(m_drop);
      s.rdy  = (rdy_cnt < 4);
      s.cp   = cm;
      @(posedge clk);
      stq.push_back(s);
      if (cm) cq.push_back(snap);
      @(negedge clk);
      frame_valid    = 1'b0;
      pwm_period_end = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) m_sh[i] = 8'h00;
      m_dirty    = 1'b0;
      m_drop     = 0;
      m_fr.delete();
      last_apply = ek;
   endtask

   initial begin
      bit          saw_full;
      int          sent;
      logic [15:0] fd;
      model_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      // single write then commit
      step(1'b1, 16'h8432, 1'b0);
      idle(3);
      check("single_pending", pending, 1);
      check("single_duty_before", duty, 8'h00);
      step(1'b0, 16'h0000, 1'b1);
      check("single_duty_after", duty, 8'h32);
      check("single_commit_pulse", commit_pulse, 1);
      check("single_pending_clear", pending, 0);
      idle(1);
      check("single_pulse_one_cycle", commit_pulse, 0);

      // invalid frames: read flag clear, and address above range
      step(1'b1, 16'h0401, 1'b0);
      idle(3);
      step(1'b1, 16'h8555, 1'b0);
      idle(3);
      check("invalid_drops", drop_count, 8'd2);
      check("invalid_pending", pending, 0);
      step(1'b0, 16'h0000, 1'b1);
      check("invalid_live", {en_out, pwm_en, duty}, 40'h00_0000_0032);

      // overflow: six back-to-back frames to address 0
      saw_full = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, 16'h8000 | 16'(i), 1'b0);
         if (!frame_ready) saw_full = 1'b1;
      end
      idle(15);
      check("overflow_ready_dropped", saw_full, 1);
      check("overflow_drops", drop_count, 8'd3);
      step(1'b0, 16'h0000, 1'b1);
      check("overflow_last_accepted", en_out[7:0], 8'h05);

      // write landing on the commit edge
      step(1'b1, 16'h8211, 1'b0);
      idle(4);
      step(1'b1, 16'h82AA, 1'b0);
      idle(2);
      step(1'b0, 16'h0000, 1'b1);
      check("simul_commit_excludes", pwm_en[7:0], 8'h11);
      check("simul_pending_stays", pending, 1);
      idle(2);
      step(1'b0, 16'h0000, 1'b1);
      check("simul_next_commit", pwm_en[7:0], 8'hAA);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         fd = {($urandom % 4) != 0, 7'($urandom % 7), 8'($urandom)};
         step(($urandom % 3) == 0, fd, ($urandom % 8) == 0);
      end
      idle(12);
      step(1'b0, 16'h0000, 1'b1);
      idle(2);

      // saturation: 300 invalid frames
      sent = 0;
      while (sent < 300) begin
         if ($urandom % 2) fd = {1'b0, 7'($urandom % 5), 8'($urandom)};
         else              fd = {1'b1, 7'(5 + $urandom % 123), 8'($urandom)};
         step(1'b1, fd, 1'b0);
         sent++;
         idle($urandom % 3);
      end
      idle(12);
      check("sat_count", drop_count, 8'd255);
      step(1'b1, 16'h0123, 1'b0);
      idle(5);
      check("sat_holds", drop_count, 8'd255);

      // asynchronous reset while the sequencer is in FETCH
      step(1'b1, 16'h8377, 1'b0);
      idle(1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_en_out", en_out, 16'h0000);
      check("rst_pwm_en", pwm_en, 16'h0000);
      check("rst_duty", duty, 8'h00);
      check("rst_pending", pending, 0);
      check("rst_commit_pulse", commit_pulse, 0);
      check("rst_drop_count", drop_count, 8'h00);
      check("rst_frame_ready", frame_ready, 1);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(6);
      check("rst_no_replay", pending, 0);
      step(1'b0, 16'h0000, 1'b1);
      check("rst_no_commit", duty, 8'h00);
      idle(2);

      check("commit_queue_drained", 64'(cq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
